// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch controller: one-word tagged fetch buffer in front of a
// variable-latency req/gnt/rvalid bus, with timeout, error fallback and fence.i flush.
module imem_fetch_ctrl #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] core_addr_i,
   output logic [31:0] core_dout_o,
   output logic        core_busy_o,
   input  logic        flush_i,
   output logic        bus_req_o,
   output logic [31:0] bus_addr_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_err_i,
   output logic        fault_o
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT
   } state_t;

   state_t        state_q, state_d;
   logic          valid_q, valid_d;
   logic [29:0]   tag_q, tag_d;
   logic [29:0]   tag_pend_q, tag_pend_d;
   logic [31:0]   data_q, data_d;
   logic          req_q, req_d;
   logic [31:0]   addr_q, addr_d;
   logic          fault_q, fault_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          discard_q, discard_d;

   logic          hit;
   logic          drop;
   logic          timeout;
   logic [1:0]    unused_addr_lsb;

   // Byte offset within the word never affects the fetch.
   assign unused_addr_lsb = core_addr_i[1:0];

   assign hit         = valid_q && (tag_q == core_addr_i[31:2]) && !flush_i;
   assign core_busy_o = !hit;
   assign core_dout_o = data_q;
   assign bus_req_o   = req_q;
   assign bus_addr_o  = addr_q;
   assign fault_o     = fault_q;

   // A flush arriving in the same cycle as the response also kills that response.
   assign drop    = discard_q || flush_i;
   assign timeout = (cnt_q == TMAX);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         valid_q    <= 1'b0;
         tag_q      <= '0;
         tag_pend_q <= '0;
         data_q     <= NOP_INST;
         req_q      <= 1'b0;
         addr_q     <= '0;
         fault_q    <= 1'b0;
         cnt_q      <= '0;
         discard_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         tag_q      <= tag_d;
         tag_pend_q <= tag_pend_d;
         data_q     <= data_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         fault_q    <= fault_d;
         cnt_q      <= cnt_d;
         discard_q  <= discard_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      tag_d      = tag_q;
      tag_pend_d = tag_pend_q;
      data_d     = data_q;
      req_d      = req_q;
      addr_d     = addr_q;
      fault_d    = 1'b0;
      cnt_d      = cnt_q;
      discard_d  = discard_q;

      unique case (state_q)
         ST_IDLE: begin
            discard_d = 1'b0;
            if (flush_i) begin
               valid_d = 1'b0;
            end else if (!hit) begin
               tag_pend_d = core_addr_i[31:2];
               req_d      = 1'b1;
               addr_d     = {core_addr_i[31:2], 2'b00};
               state_d    = ST_REQ;
            end
         end

         ST_REQ: begin
            if (flush_i) begin
               discard_d = 1'b1;
               valid_d   = 1'b0;
            end
            // Same-cycle rvalid is illegal on this bus and deliberately not looked at.
            if (bus_gnt_i) begin
               req_d   = 1'b0;
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (flush_i) begin
               discard_d = 1'b1;
               valid_d   = 1'b0;
            end
            if (bus_rvalid_i || timeout) begin
               state_d   = ST_IDLE;
               discard_d = 1'b0;
               if (bus_rvalid_i && !bus_err_i) begin
                  if (!drop) begin
                     data_d  = bus_rdata_i;
                     tag_d   = tag_pend_q;
                     valid_d = 1'b1;
                  end
               end else begin
                  fault_d = 1'b1;
                  if (!drop) begin
                     data_d  = NOP_INST;
                     tag_d   = tag_pend_q;
                     valid_d = 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: cold fetch, stalled grant, error, timeout,
// redirect, flush and mid-transaction reset.
module tb_imem_fetch_ctrl;

   localparam int unsigned TO  = 8;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] core_addr;
   logic [31:0] core_dout;
   logic        core_busy;
   logic        flush;
   logic        bus_req;
   logic [31:0] bus_addr;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;
   logic        bus_err;
   logic        fault;

   int tests = 0;
   int fails = 0;

   imem_fetch_ctrl #(.TIMEOUT(TO), .NOP_INST(NOP)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .core_addr_i (core_addr),
      .core_dout_o (core_dout),
      .core_busy_o (core_busy),
      .flush_i     (flush),
      .bus_req_o   (bus_req),
      .bus_addr_o  (bus_addr),
      .bus_gnt_i   (bus_gnt),
      .bus_rvalid_i(bus_rvalid),
      .bus_rdata_i (bus_rdata),
      .bus_err_i   (bus_err),
      .fault_o     (fault)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are then driven 1ns after the edge.
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      rst_n      = 1'b0;
      core_addr  = 32'h0;
      flush      = 1'b0;
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = 32'h0;
      bus_err    = 1'b0;

      // Reset state
      cyc; cyc;
      #1;
      check("rst_busy",  {31'b0, core_busy}, 32'd1);
      check("rst_req",   {31'b0, bus_req},   32'd0);
      check("rst_fault", {31'b0, fault},     32'd0);
      check("rst_addr",  bus_addr,           32'h0);
      check("rst_dout",  core_dout,          NOP);

      // Cold fetch of 0x0
      rst_n = 1'b1;
      #1 check("cold_c0_busy", {31'b0, core_busy}, 32'd1);
      cyc;
      check("cold_req",      {31'b0, bus_req}, 32'd1);
      check("cold_addr",     bus_addr, 32'h0);
      check("cold_c1_busy",  {31'b0, core_busy}, 32'd1);
      bus_gnt = 1'b1;
      cyc;
      bus_gnt = 1'b0;
      check("cold_req_drop", {31'b0, bus_req}, 32'd0);
      bus_rvalid = 1'b1; bus_rdata = 32'h0010_0093;
      #1 check("cold_c2_busy", {31'b0, core_busy}, 32'd1);
      cyc;
      bus_rvalid = 1'b0; bus_rdata = 32'h0;
      #1;
      check("cold_hit_busy", {31'b0, core_busy}, 32'd0);
      check("cold_dout",     core_dout, 32'h0010_0093);
      for (int i = 0; i < 3; i++) begin
         cyc;
         check("cold_hold_noreq", {31'b0, bus_req}, 32'd0);
         check("cold_hold_busy",  {31'b0, core_busy}, 32'd0);
      end

      // Stalled grant at 0x104
      core_addr = 32'h0000_0104;
      #1 check("stall_c0_busy", {31'b0, core_busy}, 32'd1);
      cyc;
      for (int i = 0; i < 5; i++) begin
         check("stall_req",  {31'b0, bus_req}, 32'd1);
         check("stall_addr", bus_addr, 32'h0000_0104);
         bus_gnt = (i == 4);
         cyc;
      end
      bus_gnt = 1'b0;
      check("stall_req_drop", {31'b0, bus_req}, 32'd0);
      cyc;
      bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
      #1 check("stall_wait_busy", {31'b0, core_busy}, 32'd1);
      cyc;
      bus_rvalid = 1'b0;
      #1;
      check("stall_busy", {31'b0, core_busy}, 32'd0);
      check("stall_dout", core_dout, 32'h1234_5678);
      core_addr = 32'h0000_0106;
      #1;
      check("stall_106_busy", {31'b0, core_busy}, 32'd0);
      check("stall_106_dout", core_dout, 32'h1234_5678);

      // Error response at 0x400
      cyc;
      core_addr = 32'h0000_0400;
      cyc;
      bus_gnt = 1'b1;
      cyc;
      bus_gnt = 1'b0;
      bus_rvalid = 1'b1; bus_err = 1'b1; bus_rdata = 32'hDEAD_BEEF;
      #1 check("err_pre_fault", {31'b0, fault}, 32'd0);
      cyc;
      bus_rvalid = 1'b0; bus_err = 1'b0;
      #1;
      check("err_fault", {31'b0, fault}, 32'd1);
      check("err_busy",  {31'b0, core_busy}, 32'd0);
      check("err_dout",  core_dout, NOP);
      cyc;
      check("err_fault_1cyc", {31'b0, fault}, 32'd0);
      check("err_still_hit",  {31'b0, core_busy}, 32'd0);

      // Timeout at 0x500
      core_addr = 32'h0000_0500;
      cyc;
      bus_gnt = 1'b1;
      cyc;
      bus_gnt = 1'b0;
      n = 0;
      while (fault !== 1'b1 && n < 20) begin
         cyc;
         n++;
      end
      tests++;
      assert (n >= TO && n <= TO + 2) else begin
         fails++;
         $error("FAIL to_cycles: got %0d expected %0d..%0d", n, TO, TO + 2);
      end
      check("to_fault", {31'b0, fault}, 32'd1);
      check("to_busy",  {31'b0, core_busy}, 32'd0);
      check("to_dout",  core_dout, NOP);
      cyc;
      check("to_fault_1cyc", {31'b0, fault}, 32'd0);
      bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_BAD0;
      cyc;
      bus_rvalid = 1'b0;
      #1;
      check("to_late_dout",  core_dout, NOP);
      check("to_late_busy",  {31'b0, core_busy}, 32'd0);
      check("to_late_fault", {31'b0, fault}, 32'd0);
      check("to_late_req",   {31'b0, bus_req}, 32'd0);

      // Redirect 0x200 -> 0x300
      core_addr = 32'h0000_0200;
      cyc;
      core_addr = 32'h0000_0300;
      check("redir_addr200", bus_addr, 32'h0000_0200);
      bus_gnt = 1'b1;
      cyc;
      bus_gnt = 1'b0;
      bus_rvalid = 1'b1; bus_rdata = 32'hAAAA_0200;
      #1 check("redir_wait_busy", {31'b0, core_busy}, 32'd1);
      cyc;
      bus_rvalid = 1'b0;
      core_addr = 32'h0000_0200;
      #1;
      check("redir_200_hit",  {31'b0, core_busy}, 32'd0);
      check("redir_200_dout", core_dout, 32'hAAAA_0200);
      core_addr = 32'h0000_0300;
      #1 check("redir_300_miss", {31'b0, core_busy}, 32'd1);
      cyc;
      check("redir_req300",  {31'b0, bus_req}, 32'd1);
      check("redir_addr300", bus_addr, 32'h0000_0300);
      bus_gnt = 1'b1;
      cyc;
      bus_gnt = 1'b0;
      bus_rvalid = 1'b1; bus_rdata = 32'hBBBB_0300;
      #1 check("redir_300_busy", {31'b0, core_busy}, 32'd1);
      cyc;
      bus_rvalid = 1'b0;
      #1;
      check("redir_300_hit",  {31'b0, core_busy}, 32'd0);
      check("redir_300_dout", core_dout, 32'hBBBB_0300);

      // Flush during WAIT at 0x600
      core_addr = 32'h0000_0600;
      cyc;
      bus_gnt = 1'b1;
      cyc;
      bus_gnt = 1'b0;
      flush = 1'b1;
      #1 check("fw_busy", {31'b0, core_busy}, 32'd1);
      cyc;
      flush = 1'b0;
      bus_rvalid = 1'b1; bus_rdata = 32'hCCCC_0600;
      cyc;
      bus_rvalid = 1'b0;
      #1;
      check("fw_discard_busy", {31'b0, core_busy}, 32'd1);
      check("fw_idle_noreq",   {31'b0, bus_req}, 32'd0);
      cyc;
      check("fw_rereq",      {31'b0, bus_req}, 32'd1);
      check("fw_rereq_addr", bus_addr, 32'h0000_0600);
      bus_gnt = 1'b1;
      cyc;
      bus_gnt = 1'b0;
      bus_rvalid = 1'b1; bus_rdata = 32'hDDDD_0600;
      cyc;
      bus_rvalid = 1'b0;
      #1;
      check("fw_busy_done", {31'b0, core_busy}, 32'd0);
      check("fw_dout",      core_dout, 32'hDDDD_0600);

      // Flush on a hit in IDLE
      flush = 1'b1;
      #1 check("fi_busy", {31'b0, core_busy}, 32'd1);
      cyc;
      flush = 1'b0;
      #1;
      check("fi_noreq",      {31'b0, bus_req}, 32'd0);
      check("fi_busy_after", {31'b0, core_busy}, 32'd1);
      cyc;
      check("fi_req",  {31'b0, bus_req}, 32'd1);
      check("fi_addr", bus_addr, 32'h0000_0600);
      bus_gnt = 1'b1;
      cyc;
      bus_gnt = 1'b0;
      bus_rvalid = 1'b1; bus_rdata = 32'hEEEE_0600;
      cyc;
      bus_rvalid = 1'b0;
      #1;
      check("fi_busy_done", {31'b0, core_busy}, 32'd0);
      check("fi_dout",      core_dout, 32'hEEEE_0600);

      // Async reset while in WAIT
      core_addr = 32'h0000_0700;
      cyc;
      bus_gnt = 1'b1;
      cyc;
      bus_gnt = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check("ar_req",   {31'b0, bus_req}, 32'd0);
      check("ar_fault", {31'b0, fault}, 32'd0);
      check("ar_busy",  {31'b0, core_busy}, 32'd1);
      check("ar_dout",  core_dout, NOP);
      cyc;
      core_addr = 32'h0;
      rst_n = 1'b1;
      #1 check("ar_cold_busy", {31'b0, core_busy}, 32'd1);
      cyc;
      check("ar_cold_req",  {31'b0, bus_req}, 32'd1);
      check("ar_cold_addr", bus_addr, 32'h0);
      bus_gnt = 1'b1;
      cyc;
      bus_gnt = 1'b0;
      bus_rvalid = 1'b1; bus_rdata = 32'h0010_0093;
      cyc;
      bus_rvalid = 1'b0;
      #1;
      check("ar_cold_hit",  {31'b0, core_busy}, 32'd0);
      check("ar_cold_dout", core_dout, 32'h0010_0093);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction-memory controller between the core's fetch port (im_addr_o / im_dout_i / im_busy_i) and a variable-latency instruction bus (req/gnt/rvalid).
- Holds a one-word tagged fetch buffer: a repeated address hits with zero latency; a new address launches a bus read and holds core_busy_o high until the word returns.
- Adds a bus timeout, error handling and a flush input for fence.i.

Parameters:
- TIMEOUT, 255: max cycles in WAIT before the read is abandoned; counter width is $clog2(TIMEOUT+1).
- NOP_INST, 32'h0000_0013: word returned on bus error or timeout (addi x0,x0,0).

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  asynchronous active-low reset
- core_addr_i  in  32  fetch address from core (im_addr_o)
- core_dout_o  out  32  instruction to core (im_dout_i)
- core_busy_o  out  1  fetch not ready, core stalls (im_busy_i)
- flush_i  in  1  invalidate buffer (fence.i), one-cycle pulse
- bus_req_o  out  1  read request
- bus_addr_o  out  32  word-aligned request address
- bus_gnt_i  in  1  request accepted this cycle
- bus_rvalid_i  in  1  read data valid
- bus_rdata_i  in  32  read data
- bus_err_i  in  1  error response, qualified by bus_rvalid_i
- fault_o  out  1  one-cycle pulse on error or timeout

Behaviour:
- Reset (async, rst_n_i low): state IDLE, valid=0, tag=0, data=NOP_INST, bus_req_o=0, bus_addr_o=0, fault_o=0, timeout counter=0.
- Address compare uses core_addr_i[31:2]; bits [1:0] are ignored. bus_addr_o is always {addr[31:2],2'b00}.
- hit = valid && (tag == core_addr_i[31:2]) && !flush_i, combinational.
- core_busy_o = !hit, combinational. core_dout_o = data register.
- core_dout_o is meaningful only when core_busy_o=0.
- FSM IDLE:
  - On a miss with !flush_i, register tag_pend=core_addr_i[31:2], set bus_req_o=1 and bus_addr_o, then go to REQ.
  - Request issue is registered: one cycle after the miss is seen.
- FSM REQ:
  - Hold bus_req_o=1 and bus_addr_o stable until bus_gnt_i=1.
  - On gnt: bus_req_o=0 next cycle, counter cleared, go to WAIT.
  - rvalid in the same cycle as gnt is not permitted by the bus and is ignored.
- FSM WAIT: counter increments each cycle without rvalid.
  - rvalid && !err: data<=bus_rdata_i, tag<=tag_pend, valid<=1, go to IDLE.
  - rvalid && err: data<=NOP_INST, tag<=tag_pend, valid<=1, fault_o pulse, go to IDLE.
  - counter==TIMEOUT without rvalid: same as err. A late rvalid later arriving in IDLE/REQ is ignored.
- Best-case miss latency:
  - cycle0: miss seen.
  - cycle1: req with same-cycle gnt.
  - cycle2: rvalid.
  - cycle3: hit, core_busy_o=0.
  - So 3 busy cycles.
- Redirect during REQ/WAIT (core_addr_i changes):
  - The outstanding read completes and is stored under tag_pend.
  - The new address then misses in IDLE and issues its own request.
  - A request is never withdrawn once bus_req_o=1.
- flush_i:
  - In IDLE: valid<=0; no request that cycle.
  - In REQ/WAIT: sets a discard flag. The returning data is dropped (valid stays 0), fault_o is still pulsed on err/timeout, and the controller returns to IDLE.
  - The discard flag clears on entering IDLE.
- Simultaneous flush_i and rvalid in WAIT: the data is discarded.
- Reset mid-transaction: all state clears immediately. The bus must tolerate an abandoned request.
- fault_o is exactly one cycle, registered with the state transition.

Test Plan:
- Cold fetch: after reset, addr 0x0000_0000, gnt in the req cycle, rvalid+rdata 0x0010_0093 two cycles after the miss -> busy for 3 cycles, then dout=0x0010_0093, busy=0; holding addr gives no further bus_req_o.
- Stalled grant: addr 0x0000_0104, gnt delayed 4 cycles, rvalid 2 cycles later -> bus_req_o/bus_addr_o=0x104 stable for 5 cycles, then data delivered; addr 0x106 also hits.
- Error and timeout:
  - rvalid with bus_err_i=1 -> dout=0x0000_0013, fault_o high exactly 1 cycle, address subsequently hits.
  - Separately, no rvalid for TIMEOUT=8 cycles -> same response, and a late rvalid is ignored.
- Redirect: request for 0x200 outstanding, core_addr_i switches to 0x300 -> 0x200 data stored, then a second request for 0x300; busy until its data arrives, then dout = 0x300 word.
- Flush:
  - flush_i during WAIT -> returned word discarded, the same address re-requested.
  - flush_i on a hit in IDLE -> busy asserted that cycle, refetch follows.
- Async reset asserted in WAIT -> bus_req_o=0, fault_o=0, busy=1 immediately; after release, a normal cold fetch succeeds.
